// File: rtl/road_scheduler_pkg.sv
// Shared codes for the four-way road scheduler: road, lamp and phase encodings
// plus the green-length clamp.
package road_scheduler_pkg;

    typedef enum logic [1:0] {
        ROAD_N = 2'd0,
        ROAD_E = 2'd1,
        ROAD_S = 2'd2,
        ROAD_W = 2'd3
    } road_t;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'd0,
        LAMP_YELLOW = 2'd1,
        LAMP_GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_t;

    // Unsigned 8-bit clamp of a sensor average into [lo, hi].
    function automatic logic [7:0] clamp_green(logic [7:0] avg, logic [7:0] lo,
                                               logic [7:0] hi);
        if (avg < lo)
            return lo;
        else if (avg > hi)
            return hi;
        else
            return avg;
    endfunction

endpackage

// File: rtl/road_scheduler_tick.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks (on count TICK_DIV-1).
module tick_gen
    import road_scheduler_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else if (cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + W'(1);
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/road_scheduler.sv
// Four-way intersection sequencer: round-robin green with sensor-sized green time
// and emergency pre-emption.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// PH_ALL_RED | every lamp red; next_road already shows the upcoming road
// PH_GREEN   | next_road lamp green, counter holds remaining green ticks
// PH_YELLOW  | next_road lamp yellow for YELLOW_T ticks
module road_scheduler
    import road_scheduler_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 60,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] avg_n,
    input  logic [7:0] avg_e,
    input  logic [7:0] avg_s,
    input  logic [7:0] avg_w,
    input  logic       emerg_req,
    input  logic [1:0] emerg_road,
    output logic [1:0] next_road,
    output logic [1:0] light_n,
    output logic [1:0] light_e,
    output logic [1:0] light_s,
    output logic [1:0] light_w,
    output logic [1:0] phase
);

    localparam logic [7:0] MIN8    = 8'(MIN_GREEN);
    localparam logic [7:0] MAX8    = 8'(MAX_GREEN);
    localparam logic [7:0] YELLOW8 = 8'(YELLOW_T);
    localparam logic [7:0] ALLRED8 = 8'(ALLRED_T);

    phase_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] road_q, road_d;
    logic       tick;
    logic [7:0] avg_sel;
    lamp_t      active_lamp;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        avg_sel = avg_n;
        case (road_q)
            2'd1:    avg_sel = avg_e;
            2'd2:    avg_sel = avg_s;
            2'd3:    avg_sel = avg_w;
            default: avg_sel = avg_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PH_ALL_RED;
            cnt_q   <= ALLRED8;
            road_q  <= ROAD_N;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            road_q  <= road_d;
        end
    end

    // Phases end on the tick that sees a count of 1 (or 0), so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        road_d  = road_q;
        if (tick) begin
            case (state_q)
                PH_ALL_RED: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = PH_GREEN;
                        cnt_d   = clamp_green(avg_sel, MIN8, MAX8);
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PH_GREEN: begin
                    if (emerg_req && (emerg_road != road_q)) begin
                        state_d = PH_YELLOW;
                        cnt_d   = YELLOW8;
                    end else if (emerg_req) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q <= 8'd1) begin
                        state_d = PH_YELLOW;
                        cnt_d   = YELLOW8;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PH_YELLOW: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = PH_ALL_RED;
                        cnt_d   = ALLRED8;
                        road_d  = emerg_req ? emerg_road : road_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = PH_ALL_RED;
                    cnt_d   = ALLRED8;
                end
            endcase
        end
    end

    always_comb begin
        active_lamp = LAMP_RED;
        case (state_q)
            PH_GREEN:  active_lamp = LAMP_GREEN;
            PH_YELLOW: active_lamp = LAMP_YELLOW;
            default:   active_lamp = LAMP_RED;
        endcase
    end

    assign light_n   = (road_q == ROAD_N) ? active_lamp : LAMP_RED;
    assign light_e   = (road_q == ROAD_E) ? active_lamp : LAMP_RED;
    assign light_s   = (road_q == ROAD_S) ? active_lamp : LAMP_RED;
    assign light_w   = (road_q == ROAD_W) ? active_lamp : LAMP_RED;
    assign next_road = road_q;
    assign phase     = state_q;

endmodule
